// File: rtl/cluster_pkg.sv
// Shared cluster hub definitions: nonce width, uplink FSM states,
// and an index-width helper that stays valid for single-entry vectors.
package cluster_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i,
// wrapping from N-1 back to 0.
module rr_arbiter
    import cluster_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // k = N visits ptr_i itself last, so a lone requester at ptr still wins
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/nonce_arbiter.sv
// Hub nonce arbiter: per-slave holding registers feeding one uplink
// transmitter in round-robin order, with overrun and drop accounting.
module nonce_arbiter
    import cluster_pkg::*;
#(
    parameter int SLAVES      = 2,
    parameter int ACK_TIMEOUT = 4,
    parameter int DROP_W      = 16
) (
    input  logic                        hash_clk,
    input  logic                        reset,
    input  logic [SLAVES-1:0]           new_nonces,
    input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
    input  logic                        serial_busy,
    output logic                        serial_send,
    output logic [NONCE_W-1:0]          golden_nonce,
    output logic [SLAVES-1:0]           pending,
    output logic [SLAVES-1:0]           overrun,
    output logic [DROP_W-1:0]           dropped_count
);

    localparam int IW = idx_w(SLAVES);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int CW = $clog2(SLAVES + 1);
    localparam int SW = ((DROP_W > CW) ? DROP_W : CW) + 1;

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 send_q, send_d;
    logic [NONCE_W-1:0]   gold_q, gold_d;
    logic [NONCE_W-1:0]   hold_q [SLAVES];
    logic [NONCE_W-1:0]   hold_d [SLAVES];
    logic [SLAVES-1:0]    pend_q, pend_d;
    logic [SLAVES-1:0]    ovr_q, ovr_d;
    logic [DROP_W-1:0]    drop_q, drop_d;

    logic [SLAVES-1:0]    gnt;
    logic [IW-1:0]        gidx;
    logic                 gany;
    logic                 grant;
    logic [CW-1:0]        ndrop;
    logic [SW-1:0]        dsum;

    rr_arbiter #(
        .N  (SLAVES),
        .IW (IW)
    ) u_rr (
        .req_i (pend_q),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign grant = (state_q == IDLE) && gany && !serial_busy;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        send_d  = 1'b0;
        gold_d  = gold_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    gold_d  = hold_q[gidx];
                    ptr_d   = gidx;
                    send_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (serial_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!serial_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing the granted flag first means a same-cycle re-pulse is kept, not dropped
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        hold_d = hold_q;
        ndrop  = '0;
        if (grant) pend_d[gidx] = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) begin
                hold_d[i] = slave_nonces[i*NONCE_W +: NONCE_W];
                if (pend_d[i]) begin
                    ovr_d[i] = 1'b1;
                    ndrop    = ndrop + CW'(1);
                end
                pend_d[i] = 1'b1;
            end
        end
        dsum   = SW'(drop_q) + SW'(ndrop);
        drop_d = (dsum > SW'({DROP_W{1'b1}})) ? '1 : dsum[DROP_W-1:0];
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(SLAVES - 1);
            tmo_q   <= '0;
            send_q  <= 1'b0;
            gold_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            drop_q  <= '0;
            for (int i = 0; i < SLAVES; i++) hold_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            send_q  <= send_d;
            gold_q  <= gold_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
        end
    end

    assign serial_send   = send_q;
    assign golden_nonce  = gold_q;
    assign pending       = pend_q;
    assign overrun       = ovr_q;
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// Bench for nonce_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed words and timings.
module tb_nonce_arbiter;

    localparam int S  = 4;
    localparam int T  = 4;
    localparam int DW = 3;
    localparam int DMAX = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [S-1:0]    new_nonces = '0;
    logic [S*32-1:0] slave_nonces = '0;
    logic            serial_busy = 1'b0;
    logic            serial_send;
    logic [31:0]     golden_nonce;
    logic [S-1:0]    pending;
    logic [S-1:0]    overrun;
    logic [DW-1:0]   dropped_count;

    nonce_arbiter #(
        .SLAVES      (S),
        .ACK_TIMEOUT (T),
        .DROP_W      (DW)
    ) dut (
        .hash_clk      (clk),
        .reset         (reset),
        .new_nonces    (new_nonces),
        .slave_nonces  (slave_nonces),
        .serial_busy   (serial_busy),
        .serial_send   (serial_send),
        .golden_nonce  (golden_nonce),
        .pending       (pending),
        .overrun       (overrun),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Uplink stand-in: busy for busy_len cycles per send, never if busy_len is 0
    int busy_len = 0;
    int busy_rem = 0;
    bit ul_flush = 0;

    always @(negedge clk) begin
        if (ul_flush) begin
            serial_busy = 1'b0;
            busy_rem = 0;
        end else if (serial_send && busy_len > 0) begin
            serial_busy = 1'b1;
            busy_rem = busy_len;
        end else if (busy_rem > 0) begin
            busy_rem--;
            if (busy_rem == 0) serial_busy = 1'b0;
        end
    end

    // Model: words waiting per slave, whether the link is reserved, rr order
    logic [31:0] m_hold [S];
    logic [S-1:0] m_pend, m_ovr;
    int m_drop, m_ptr, m_waited, g;
    bit m_await, m_xfer;
    logic m_send;
    logic [31:0] m_gold;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < S; i++) m_hold[i] = '0;
            m_pend = '0;
            m_ovr = '0;
            m_drop = 0;
            m_ptr = S - 1;
            m_await = 0;
            m_xfer = 0;
            m_waited = 0;
            m_send = 0;
            m_gold = '0;
        end else begin
            g = -1;
            m_send = 0;
            if (m_await) begin
                if (serial_busy) begin
                    m_await = 0;
                    m_xfer = 1;
                end else begin
                    m_waited++;
                    if (m_waited >= T) m_await = 0;
                end
            end else if (m_xfer) begin
                if (!serial_busy) m_xfer = 0;
            end else if (m_pend != 0 && !serial_busy) begin
                for (int k = 1; k <= S; k++)
                    if (g < 0 && m_pend[(m_ptr + k) % S]) g = (m_ptr + k) % S;
                m_gold = m_hold[g];
                m_pend[g] = 1'b0;
                m_ptr = g;
                m_await = 1;
                m_waited = 0;
                m_send = 1;
            end
            for (int i = 0; i < S; i++) begin
                if (new_nonces[i]) begin
                    if (m_pend[i]) begin
                        m_ovr[i] = 1'b1;
                        m_drop = (m_drop + 1 > DMAX) ? DMAX : m_drop + 1;
                    end
                    m_hold[i] = slave_nonces[i*32 +: 32];
                    m_pend[i] = 1'b1;
                end
            end
        end
    end

    logic [31:0] sent_q [$];
    int sent_cyc [$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("serial_send", 32'(serial_send), 32'(m_send));
            chk("golden_nonce", golden_nonce, m_gold);
            chk("pending", 32'(pending), 32'(m_pend));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("dropped_count", 32'(dropped_count), m_drop);
            if (serial_send) begin
                sent_q.push_back(golden_nonce);
                sent_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fire(input logic [S-1:0] m, input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
        new_nonces = m;
        slave_nonces = {v3, v2, v1, v0};
        tick();
        new_nonces = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ul_flush = 1'b1;
        new_nonces = '0;
        tick();
        tick();
        reset = 1'b0;
        ul_flush = 1'b0;
        sent_q.delete();
        sent_cyc.delete();
    endtask

    task automatic wait_sent(input int n, input int budget);
        int b;
        b = 0;
        while (sent_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk("wait_sent", sent_q.size(), n);
    endtask

    int c0;

    initial begin
        do_reset();
        chk_en = 1;
        chk("reset_send", 32'(serial_send), 0);
        chk("reset_pending", 32'(pending), 0);

        // single word, idle link: 2-clock latency
        busy_len = 3;
        c0 = cyc;
        fire(4'b0001, 32'hDEADBEEF, 0, 0, 0);
        wait_sent(1, 20);
        chk("t1_latency", sent_cyc[0] - c0, 2);
        chk("t1_word", sent_q[0], 32'hDEADBEEF);
        chk("t1_pending", 32'(pending), 0);
        chk("t1_send", 32'(serial_send), 1);
        repeat (8) tick();

        // two simultaneous sources
        do_reset();
        busy_len = 10;
        fire(4'b0011, 32'h11111111, 32'h22222222, 0, 0);
        wait_sent(2, 60);
        chk("t2_first", sent_q[0], 32'h11111111);
        chk("t2_second", sent_q[1], 32'h22222222);
        chk("t2_gap", sent_cyc[1] - sent_cyc[0], 12);
        chk("t2_overrun", 32'(overrun), 0);

        // overwrite while link busy
        do_reset();
        busy_len = 10;
        fire(4'b0001, 32'h100, 0, 0, 0);
        wait_sent(1, 20);
        tick();
        fire(4'b0010, 0, 32'hA, 0, 0);
        fire(4'b0010, 0, 32'hB, 0, 0);
        wait_sent(2, 60);
        chk("t3_word", sent_q[1], 32'hB);
        chk("t3_overrun", 32'(overrun), 32'h2);
        chk("t3_drop", 32'(dropped_count), 1);
        repeat (20) tick();
        chk("t3_count", sent_q.size(), 2);

        // drop counter saturation
        do_reset();
        busy_len = 40;
        fire(4'b1000, 0, 0, 0, 32'h300);
        wait_sent(1, 20);
        for (int i = 0; i < 10; i++) fire(4'b0100, 0, 0, 32'h200 + i, 0);
        chk("sat_drop", 32'(dropped_count), DMAX);
        chk("sat_overrun", 32'(overrun), 32'h4);

        // round-robin fairness over three rounds
        do_reset();
        busy_len = 2;
        for (int r = 0; r < 3; r++) begin
            fire(4'b1111, 32'h40000000 + r*256, 32'h40000001 + r*256,
                 32'h40000002 + r*256, 32'h40000003 + r*256);
            wait_sent(4*(r+1), 80);
        end
        for (int k = 0; k < 12; k++)
            chk($sformatf("t4_order%0d", k), sent_q[k], 32'h40000000 + (k/4)*256 + (k%4));
        chk("t4_drop", 32'(dropped_count), 0);

        // re-pulse on the grant edge
        do_reset();
        busy_len = 2;
        fire(4'b0001, 32'h50, 0, 0, 0);
        fire(4'b0001, 32'h51, 0, 0, 0);
        wait_sent(2, 40);
        chk("t5_old", sent_q[0], 32'h50);
        chk("t5_new", sent_q[1], 32'h51);
        chk("t5_drop", 32'(dropped_count), 0);
        chk("t5_overrun", 32'(overrun), 0);

        // reset mid-transfer, then ack timeout
        do_reset();
        busy_len = 30;
        fire(4'b0001, 32'h60, 0, 0, 0);
        wait_sent(1, 20);
        repeat (3) tick();
        fire(4'b0110, 0, 32'h61, 32'h62, 0);
        tick();
        chk("t6_pre_pending", 32'(pending), 32'h6);
        reset = 1'b1;
        ul_flush = 1'b1;
        tick();
        chk("t6_send", 32'(serial_send), 0);
        chk("t6_gold", golden_nonce, 0);
        chk("t6_pending", 32'(pending), 0);
        chk("t6_overrun", 32'(overrun), 0);
        chk("t6_drop", 32'(dropped_count), 0);
        reset = 1'b0;
        ul_flush = 1'b0;
        sent_q.delete();
        sent_cyc.delete();
        busy_len = 0;
        c0 = cyc;
        fire(4'b0001, 32'h63, 0, 0, 0);
        wait_sent(1, 20);
        chk("t6_latency", sent_cyc[0] - c0, 2);
        fire(4'b0010, 0, 32'h64, 0, 0);
        wait_sent(2, 30);
        chk("t6_timeout_gap", sent_cyc[1] - sent_cyc[0], T + 1);
        chk("t6_second", sent_q[1], 32'h64);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
